// File: rtl/riscv_mmio_ctrl.sv
// riscv_mmio_ctrl: MMIO block that sits beside DMEM in the memory/writeback stage.
// It provides UART RX/TX FIFOs, a cycle counter and a retired-instruction counter.
// Read data is registered, so it appears one cycle after the request, the same
// timing as DMEM/BIOS.
// Optional build macro MMIO_BRANCH_CNT_EN adds branch and taken-branch counters,
// readable at offsets 0x1C and 0x20.
module riscv_mmio_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          RX_DEPTH  = 8,
   parameter int          TX_DEPTH  = 8,
   parameter int          CNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   input  logic        inst_retire,
   input  logic        br_retire,
   input  logic        br_taken,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready
);

   localparam int RX_PW = $clog2(RX_DEPTH);
   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam logic [RX_PW:0] RX_FULL_CNT = (RX_PW + 1)'(RX_DEPTH);
   localparam logic [TX_PW:0] TX_FULL_CNT = (TX_PW + 1)'(TX_DEPTH);

   // Word offsets (req_addr[7:2])
   localparam logic [5:0] OFF_STATUS = 6'h00;
   localparam logic [5:0] OFF_RXDATA = 6'h01;
   localparam logic [5:0] OFF_TXDATA = 6'h02;
   localparam logic [5:0] OFF_CYCLE  = 6'h04;
   localparam logic [5:0] OFF_INSTR  = 6'h05;
   localparam logic [5:0] OFF_CLEAR  = 6'h06;
   localparam logic [5:0] OFF_BR     = 6'h07;
   localparam logic [5:0] OFF_BRTKN  = 6'h08;

   logic [5:0]  offset;
   logic        hit;
   logic        wr_req;
   logic        rd_req;
   logic        rd_load;
   logic [31:0] rd_mux;

   // Address bits [1:0] and the upper write-data bytes are not used by any register.
   logic        unused_bits;
   assign unused_bits = ^{req_addr[1:0], req_wdata[31:8]};

   assign offset  = req_addr[7:2];
   assign hit     = req_en && (req_addr[31:8] == BASE_ADDR[31:8]);
   assign wr_req  = hit && (req_we != 4'b0000);
   assign rd_req  = hit && (req_we == 4'b0000);
   // A read outside the window still loads rdata, with zero.
   assign rd_load = req_en && (req_we == 4'b0000);

   // ------------------------------------------------------------------ RX FIFO
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_PW-1:0] rx_wr_ptr;
   logic [RX_PW-1:0] rx_rd_ptr;
   logic [RX_PW:0]   rx_count;
   logic             rx_full;
   logic             rx_empty;
   logic             rx_push;
   logic             rx_pop;

   assign rx_full       = (rx_count == RX_FULL_CNT);
   assign rx_empty      = (rx_count == '0);
   assign uart_rx_ready = !rx_full;
   assign rx_push       = uart_rx_valid && !rx_full;
   assign rx_pop        = rd_req && (offset == OFF_RXDATA) && !rx_empty;

   // RX pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   // RX storage. It is not reset, because the occupancy count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
   end

   // ------------------------------------------------------------------ TX FIFO
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_PW-1:0] tx_wr_ptr;
   logic [TX_PW-1:0] tx_rd_ptr;
   logic [TX_PW:0]   tx_count;
   logic             tx_full;
   logic             tx_empty;
   logic             tx_wr;
   logic             tx_push;
   logic             tx_pop;
   logic             tx_overflow;

   assign tx_full       = (tx_count == TX_FULL_CNT);
   assign tx_empty      = (tx_count == '0);
   assign uart_tx_valid = !tx_empty;
   assign uart_tx_data  = tx_mem[tx_rd_ptr];
   assign tx_wr         = wr_req && (offset == OFF_TXDATA);
   // Fullness is judged before any same-cycle UART pop, so a write to a full FIFO is dropped.
   assign tx_push       = tx_wr && !tx_full;
   assign tx_pop        = !tx_empty && uart_tx_ready;

   // TX pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wr_ptr   <= '0;
         tx_rd_ptr   <= '0;
         tx_count    <= '0;
         tx_overflow <= 1'b0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
         if (tx_wr && tx_full)
            tx_overflow <= 1'b1;
         else if (wr_req && (offset == OFF_STATUS))
            tx_overflow <= 1'b0;
      end
   end

   // TX storage, holding the bytes queued for the UART transmitter.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= req_wdata[7:0];
   end

   // ----------------------------------------------------------------- counters
   logic                 cnt_clr;
   logic [CNT_WIDTH-1:0] cycle_cnt;
   logic [CNT_WIDTH-1:0] instr_cnt;

   assign cnt_clr = wr_req && (offset == OFF_CLEAR);

   // Cycle and retired-instruction counters. A clear takes priority over an increment in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (inst_retire) instr_cnt <= instr_cnt + 1'b1;
      end
   end

   logic [31:0] br_rd;
   logic [31:0] br_taken_rd;

`ifdef MMIO_BRANCH_CNT_EN
   logic [CNT_WIDTH-1:0] br_cnt;
   logic [CNT_WIDTH-1:0] br_taken_cnt;

   // Branch counters. They use the same clear priority and wrap-around as the base counters.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         br_cnt       <= '0;
         br_taken_cnt <= '0;
      end else if (br_retire) begin
         br_cnt <= br_cnt + 1'b1;
         if (br_taken) br_taken_cnt <= br_taken_cnt + 1'b1;
      end
   end

   assign br_rd       = 32'(br_cnt);
   assign br_taken_rd = 32'(br_taken_cnt);
`else
   logic unused_br;
   assign unused_br   = br_retire ^ br_taken;
   assign br_rd       = 32'h0;
   assign br_taken_rd = 32'h0;
`endif

   // ---------------------------------------------------------------- read path
   // Register read multiplexer. Offsets with no register mapped read as zero.
   always_comb begin
      rd_mux = 32'h0;
      case (offset)
         OFF_STATUS: rd_mux = {29'h0, tx_overflow, !rx_empty, !tx_full};
         OFF_RXDATA: rd_mux = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
         OFF_CYCLE:  rd_mux = 32'(cycle_cnt);
         OFF_INSTR:  rd_mux = 32'(instr_cnt);
         OFF_BR:     rd_mux = br_rd;
         OFF_BRTKN:  rd_mux = br_taken_rd;
         default:    rd_mux = 32'h0;
      endcase
   end

   // Registered read data. It loads only on a read request and otherwise holds its value.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= 32'h0;
      else if (rd_load)
         rdata <= rd_req ? rd_mux : 32'h0;
   end

endmodule

// File: tb/tb_riscv_mmio_ctrl.sv
// Directed testbench for riscv_mmio_ctrl. It checks status and FIFO behaviour,
// the counters, and the branch-counter build option (MMIO_BRANCH_CNT_EN).
// A second instance, built with CNT_WIDTH=4, exercises counter wrap-around.
module tb_riscv_mmio_ctrl;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_en = 1'b0;
   logic [3:0]  req_we = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        inst_retire = 1'b0;
   logic        br_retire = 1'b0;
   logic        br_taken = 1'b0;
   logic [7:0]  uart_rx_data = 8'h0;
   logic        uart_rx_valid = 1'b0;
   logic        uart_tx_ready = 1'b0;

   logic [31:0] rdata;
   logic        uart_rx_ready;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;

   logic [31:0] rdata4;
   logic        rx_ready4;
   logic [7:0]  tx_data4;
   logic        tx_valid4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   riscv_mmio_ctrl u_dut (
      .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .rdata(rdata), .inst_retire(inst_retire),
      .br_retire(br_retire), .br_taken(br_taken), .uart_rx_data(uart_rx_data),
      .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
      .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
      .uart_tx_ready(uart_tx_ready)
   );

   riscv_mmio_ctrl #(.CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .rdata(rdata4), .inst_retire(inst_retire),
      .br_retire(br_retire), .br_taken(br_taken), .uart_rx_data(uart_rx_data),
      .uart_rx_valid(uart_rx_valid), .uart_rx_ready(rx_ready4),
      .uart_tx_data(tx_data4), .uart_tx_valid(tx_valid4),
      .uart_tx_ready(uart_tx_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
      req_en = 1'b1; req_we = 4'hF; req_addr = addr; req_wdata = data;
      tick();
      req_en = 1'b0; req_we = 4'h0;
   endtask

   task automatic mmio_read(input logic [31:0] addr);
      req_en = 1'b1; req_we = 4'h0; req_addr = addr;
      tick();
      req_en = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      mmio_read(addr);
      check(tag, rdata, exp);
   endtask

   initial begin
      int k;
      logic [31:0] exp_br, exp_brt;

      // 1: reset state
      tick(); tick();
      rst = 1'b0;
      check("rst_rdata", rdata, 32'h0);
      check("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
      check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
      read_check("rst_status", BASE + 32'h00, 32'h1);
      read_check("status_lowbits", BASE + 32'h03, 32'h1);

      // Accesses outside the window, or to unmapped offsets, have no effect and read zero.
      mmio_write(32'h9000_0008, 32'h77);
      check("oow_no_push", 32'(uart_tx_valid), 32'h0);
      read_check("oow_read", 32'h9000_0000, 32'h0);
      read_check("unmapped_read", BASE + 32'h0C, 32'h0);

      // 2: TX fill and overflow, then drain
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) mmio_write(BASE + 32'h08, 32'h41 + 32'(i));
      check("tx_valid_full", 32'(uart_tx_valid), 32'h1);
      check("tx_head", 32'(uart_tx_data), 32'h41);
      read_check("tx_ovf_status", BASE + 32'h00, 32'h4);
      uart_tx_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 20 && k < 8; c++) begin
         if (uart_tx_valid) begin
            check("tx_byte", 32'(uart_tx_data), 32'h41 + 32'(k));
            k++;
         end
         tick();
      end
      check("tx_drain_count", 32'(k), 32'd8);
      check("tx_empty_after", 32'(uart_tx_valid), 32'h0);
      read_check("tx_status_sticky", BASE + 32'h00, 32'h5);
      mmio_write(BASE + 32'h00, 32'h0);
      check("rdata_hold", rdata, 32'h5);
      read_check("tx_status_clr", BASE + 32'h00, 32'h1);

      // 3: RX fill, then read back
      for (int i = 0; i < 8; i++) begin
         uart_rx_valid = 1'b1;
         uart_rx_data  = 8'(8'h10 + i);
         tick();
      end
      uart_rx_valid = 1'b0;
      check("rx_ready_full", 32'(uart_rx_ready), 32'h0);
      read_check("rx_status", BASE + 32'h00, 32'h3);
      for (int i = 0; i < 8; i++) begin
         read_check("rx_byte", BASE + 32'h04, 32'h10 + 32'(i));
         if (i == 0) check("rx_ready_after_pop", 32'(uart_rx_ready), 32'h1);
      end
      read_check("rx_empty_read", BASE + 32'h04, 32'h0);
      read_check("rx_status_empty", BASE + 32'h00, 32'h1);
      uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; tick(); uart_rx_valid = 1'b0;
      read_check("rx_no_ptr_move", BASE + 32'h04, 32'h5A);

      // 4: RX push and CPU pop in the same cycle
      uart_rx_valid = 1'b1; uart_rx_data = 8'hAA; tick();
      uart_rx_data = 8'hBB;
      mmio_read(BASE + 32'h04);
      uart_rx_valid = 1'b0;
      check("rx_simul_old", rdata, 32'hAA);
      read_check("rx_simul_new", BASE + 32'h04, 32'hBB);
      read_check("rx_simul_empty", BASE + 32'h04, 32'h0);
      read_check("rx_simul_status", BASE + 32'h00, 32'h1);

      // 5: counters. 100 cycles after a clear, with 60 of them retiring an instruction.
      mmio_write(BASE + 32'h18, 32'h0);
      for (int i = 0; i < 100; i++) begin
         inst_retire = ((i % 5) < 3);
         tick();
      end
      inst_retire = 1'b0;
      mmio_read(BASE + 32'h14);
      check("instr_60", rdata, 32'd60);
      check("instr_w4_wrap", rdata4, 32'd12);
      read_check("cycle_101", BASE + 32'h10, 32'd101);
      inst_retire = 1'b1;
      mmio_write(BASE + 32'h18, 32'h0);
      inst_retire = 1'b0;
      read_check("cycle_clr", BASE + 32'h10, 32'h0);
      read_check("instr_clr", BASE + 32'h14, 32'h0);
      inst_retire = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      inst_retire = 1'b0;
      mmio_read(BASE + 32'h14);
      check("instr_16", rdata, 32'd16);
      check("instr_w4_zero", rdata4, 32'h0);

      // 6: branch counters (read as zero when the option is not built)
      for (int i = 0; i < 10; i++) begin
         br_retire = 1'b1;
         br_taken  = (i < 3);
         tick();
      end
      br_retire = 1'b0; br_taken = 1'b1; tick(); br_taken = 1'b0;
`ifdef MMIO_BRANCH_CNT_EN
      exp_br = 32'd10; exp_brt = 32'd3;
`else
      exp_br = 32'd0;  exp_brt = 32'd0;
`endif
      read_check("br_cnt", BASE + 32'h1C, exp_br);
      read_check("br_taken_cnt", BASE + 32'h20, exp_brt);

      // Reset in mid-operation discards buffered bytes and the overflow flag.
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) mmio_write(BASE + 32'h08, 32'h60 + 32'(i));
      uart_rx_valid = 1'b1; uart_rx_data = 8'h33; tick(); uart_rx_valid = 1'b0;
      mmio_read(BASE + 32'h00);
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrst_rdata", rdata, 32'h0);
      check("midrst_tx_valid", 32'(uart_tx_valid), 32'h0);
      read_check("midrst_status", BASE + 32'h00, 32'h1);
      read_check("midrst_rx_read", BASE + 32'h04, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
